// File: rtl/i2c_master_txn.sv
// Byte-level I2C master: one register write or read per request, with an
// optional repeated START for reads. SDA is open-drain via sda_oe.
module i2c_master_txn #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        rw,
    input  logic [6:0]  id,
    input  logic [2:0]  add_nbyte,
    input  logic [2:0]  data_nbyte,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        sda_i,
    output logic        scl_o,
    output logic        sda_oe,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic [31:0] rdata
);
    typedef enum logic [3:0] {
        IDLE, START, DEV, DACK, REG, RACK, WDATA, WACK,
        RSTART, RDATA, MACK, STOP, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [9:0]  tick_cnt;
    logic [1:0]  qtr;
    logic [2:0]  bit_cnt, byte_cnt;
    logic [2:0]  add_n, data_n;
    logic [6:0]  id_q;
    logic [31:0] addr_q, wdata_q;
    logic        rw_q, rd_phase, sda_s;
    logic        capture, tick, bit_end, sample, nack, last_add, last_data;
    logic [7:0]  tx_byte;
    logic        tx_bit;

    function automatic logic [2:0] clamp(input logic [2:0] n);
        if (n == 3'd0) return 3'd1;
        if (n > 3'd4) return 3'd4;
        return n;
    endfunction

    // Byte k of an n-byte field, counting from the most significant sent byte.
    function automatic logic [7:0] pick(input logic [31:0] w, input logic [2:0] n,
                                        input logic [2:0] k);
        logic [1:0] idx;
        idx = 2'(n - k - 3'd1);
        return w[8*idx +: 8];
    endfunction

    assign capture   = (state == IDLE) && req;
    assign tick      = (tick_cnt == 10'(CLK_DIV - 1));
    assign bit_end   = tick && (qtr == 2'd3);
    assign sample    = (qtr == 2'd3) && (tick_cnt == 10'd0);
    assign nack      = sda_s;
    assign last_add  = (byte_cnt == add_n - 3'd1);
    assign last_data = (byte_cnt == data_n - 3'd1);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_nxt = state;
        scl_o     = 1'b1;
        sda_oe    = 1'b0;
        case (state)
            DEV:     tx_byte = {id_q, rd_phase};
            REG:     tx_byte = pick(addr_q, add_n, byte_cnt);
            default: tx_byte = pick(wdata_q, data_n, byte_cnt);
        endcase
        tx_bit = tx_byte[~bit_cnt];

        case (state)
            IDLE:    if (req) state_nxt = START;
            START:   if (bit_end) state_nxt = DEV;
            RSTART:  if (bit_end) state_nxt = DEV;
            DEV:     if (bit_end && bit_cnt == 3'd7) state_nxt = DACK;
            REG:     if (bit_end && bit_cnt == 3'd7) state_nxt = RACK;
            WDATA:   if (bit_end && bit_cnt == 3'd7) state_nxt = WACK;
            RDATA:   if (bit_end && bit_cnt == 3'd7) state_nxt = MACK;
            DACK:    if (bit_end) state_nxt = nack ? STOP : (rd_phase ? RDATA : REG);
            RACK:    if (bit_end) state_nxt = nack ? STOP : (!last_add ? REG : (rw_q ? RSTART : WDATA));
            WACK:    if (bit_end) state_nxt = (nack || last_data) ? STOP : WDATA;
            MACK:    if (bit_end) state_nxt = last_data ? STOP : RDATA;
            STOP:    if (bit_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        case (state)
            START, RSTART: begin
                scl_o  = ~qtr[1];
                sda_oe = (qtr != 2'd0);
            end
            DEV, REG, WDATA: begin
                scl_o  = qtr[1];
                sda_oe = ~tx_bit;
            end
            DACK, RACK, WACK, RDATA: scl_o = qtr[1];
            MACK: begin
                scl_o  = qtr[1];
                sda_oe = ~last_data;
            end
            STOP: begin
                scl_o  = (qtr != 2'd0);
                sda_oe = ~qtr[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            qtr      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            add_n    <= 3'd1;
            data_n   <= 3'd1;
            id_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
            rd_phase <= 1'b0;
            sda_s    <= 1'b1;
            ack_err  <= 1'b0;
            rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                add_n    <= clamp(add_nbyte);
                data_n   <= clamp(data_nbyte);
                id_q     <= id;
                addr_q   <= addr;
                wdata_q  <= wdata;
                rw_q     <= rw;
                rd_phase <= 1'b0;
                tick_cnt <= '0;
                qtr      <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                ack_err  <= 1'b0;
                rdata    <= '0;
            end else if (busy) begin
                tick_cnt <= tick ? 10'd0 : tick_cnt + 10'd1;
                if (tick) qtr <= qtr + 2'd1;
                if (sample) begin
                    sda_s <= sda_i;
                    if (state == RDATA) rdata <= {rdata[30:0], sda_i};
                end
                if (bit_end) begin
                    // bit_cnt only advances inside a byte, so it wraps 7->0 exactly at the boundary
                    case (state)
                        DEV, REG, WDATA, RDATA: bit_cnt <= bit_cnt + 3'd1;
                        DACK:                   byte_cnt <= 3'd0;
                        RACK:                   byte_cnt <= last_add ? 3'd0 : byte_cnt + 3'd1;
                        WACK, MACK:             byte_cnt <= byte_cnt + 3'd1;
                        RSTART:                 rd_phase <= 1'b1;
                        default: ;
                    endcase
                    if ((state == DACK || state == RACK || state == WACK) && sda_s)
                        ack_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/i2c_master_txn.md
Name: i2c_master_txn

Overview:
- Byte-level I2C master that generates the scl/sda traffic consumed by the i2c_slave stage.
- Performs one complete register write or read per request: device id, 1-4 register-address bytes, 1-4 data bytes, MSB first.
- The address and data byte counts match the slave's add_nbyte/data_nbyte.
- Drives an open-drain SDA through sda_oe and samples the bus through sda_i. It is the bus stimulus source for the slave test wrapper and for silicon bring-up.

Parameters:
- CLK_DIV, 4, system clocks per quarter SCL period. One SCL bit = 4*CLK_DIV clocks. Legal range 2..1023.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req  in  1  one-cycle transaction request; sampled only when busy=0
- rw  in  1  0=write, 1=read
- id  in  7  7-bit target address
- add_nbyte  in  3  register-address bytes, 1..4
- data_nbyte  in  3  data bytes, 1..4
- addr  in  32  register address; the low add_nbyte bytes are sent, most-significant sent byte first
- wdata  in  32  write data; the low data_nbyte bytes are sent, most-significant first
- sda_i  in  1  sampled SDA bus level
- scl_o  out  1  SCL level
- sda_oe  out  1  1 = pull SDA low; 0 = release (bus high)
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- ack_err  out  1  valid with done; 1 = any slave byte NACKed
- rdata  out  32  read bytes, right-aligned; first byte received is most significant; upper bytes zero

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: scl_o=1, sda_oe=0, busy=0, done=0, ack_err=0, rdata=0, FSM=IDLE, tick counter=0.
- Asserting rst mid-transfer releases the bus immediately, with no STOP generated.

Request capture and ticks:
- On req with busy=0, latch all inputs and set busy=1 on the next cycle.
- req while busy=1 is ignored.
- Illegal counts (0, or >4) are clamped to 1 and 4 respectively.
- A quarter tick fires every CLK_DIV clocks while busy; the counter restarts on request capture.

Bit timing (4 quarters per bit):
- Q0: scl low, update sda_oe.
- Q1: scl low.
- Q2: scl high.
- Q3: scl high; sda_i is sampled at the first clock of Q3.
- SDA changes only in Q0.

States:
- IDLE -> START:
  - Q0 sda released, scl high.
  - Q1 sda low, scl high (START condition).
  - Q2-Q3 sda low, scl low.
- START -> DEV: send {id, W} when write or when a read's address phase is pending; send {id, R} after RSTART.
- DEV -> DACK:
  - Release SDA and sample the ACK.
  - sda_i=1 (NACK): set ack_err and go to STOP.
- DACK, write phase -> REG: send add_nbyte bytes.
- REG -> RACK after each byte; NACK goes to STOP with ack_err set.
- After the last address byte:
  - Write: go to WDATA.
  - Read: go to RSTART, a repeated START with the same waveform as START, then DEV with R=1.
- WDATA -> WACK for each byte; NACK goes to STOP. After the last byte, go to STOP.
- RDATA:
  - sda_oe=0 for 8 bits; shift sampled bits into rdata.
  - Then MACK: master drives ACK (sda_oe=1) for every byte except the last, which gets NACK (sda_oe=0).
  - After the last byte, go to STOP.
- STOP:
  - Q0 scl low, sda low.
  - Q1 scl high, sda low.
  - Q2 scl high, sda released (STOP condition).
  - Q3 idle high.
  - Then DONE.
- DONE: done=1 for one clock, busy=0 next cycle, return to IDLE. rdata and ack_err hold until the next request capture.

Counters:
- 3-bit bit counter, 3-bit byte counter.
- The bit counter wraps 7 -> 0 at the byte boundary only.

rdata rules:
- rdata clears at request capture.
- A write leaves rdata=0.

Test Plan:
- Write, CLK_DIV=4, id=0x23, add_nbyte=2, addr=0x0010, data_nbyte=2, wdata=0x4546, slave model ACKs all bytes.
  - Required bus sequence: START, 0x46, 0x00, 0x10, 0x45, 0x46, STOP.
  - Each bit lasts 16 clocks.
  - done pulses once with ack_err=0.
  - busy spans from request+1 through done.
- Read, id=0x23, add_nbyte=2, addr=0x0000, data_nbyte=2, slave returns 0x45, 0x46.
  - Required bus sequence: START, 0x46, 0x00, 0x00, repeated START, 0x47, two read bytes, STOP.
  - Master ACKs the first read byte and NACKs the second.
  - rdata=0x00004546, ack_err=0.
- Address NACK: no device responds (sda_i stays 1) -> after the DEV byte, STOP is issued immediately, done pulses with ack_err=1, and no REG bytes appear.
- NACK on the second write data byte -> STOP follows that ACK slot, ack_err=1, total 5 bytes on the bus.
- Reset mid-transfer: assert rst during the REG byte -> scl_o=1, sda_oe=0, busy=0 in the same cycle. After release, a new req=1 completes normally.
- req pulsed while busy, plus boundary counts (add_nbyte=0, data_nbyte=7) -> the busy request is ignored. The counts are clamped to 1 and 4, so 1 address byte and 4 data bytes are transferred.
